// File: rtl/adder_stream_src_if.sv
// Beat stream from adder_stream_src towards a simple_adder lane (din_valid/din).
// No backpressure: the master strobes valid and the slave must take every beat.
interface adder_stream_src_if #(
   parameter int unsigned Width = 8
);
   logic             valid;
   logic [Width-1:0] data;

   modport master (output valid, data);
   modport slave  (input  valid, data);
endinterface

// File: rtl/adder_stream_src.sv
// Burst traffic source: NUM beats of ramp data separated by a fixed idle gap.
// Define ADDER_SRC_LFSR_EN to add the mode port and a Galois LFSR data sequence.
module adder_stream_src #(
   parameter int unsigned      Width = 8,
   parameter int unsigned      CntW  = 16,
   parameter int unsigned      GapW  = 8,
   parameter logic [Width-1:0] Poly  = 8'hB8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [CntW-1:0]  num_beats_i,
   input  logic [GapW-1:0]  gap_i,
   input  logic [Width-1:0] seed_i,
   input  logic [Width-1:0] step_i,
`ifdef ADDER_SRC_LFSR_EN
   input  logic             mode_i,
`endif
   output logic             busy_o,
   output logic             done_o,
   output logic [CntW-1:0]  beats_sent_o,
   adder_stream_src_if.master tx
);

   typedef enum logic [1:0] {StIdle, StSend, StGap, StDone} state_e;

   state_e           state_q, state_d;
   logic [CntW-1:0]  num_q, num_d;
   logic [CntW-1:0]  beats_q, beats_d;
   logic [GapW-1:0]  gap_q, gap_d;
   logic [GapW-1:0]  gap_cnt_q, gap_cnt_d;
   logic [Width-1:0] step_q, step_d;
   logic [Width-1:0] data_q, data_d;
   logic             done_q, done_d;
   logic [Width-1:0] seed_eff;
   logic [Width-1:0] data_next;

`ifdef ADDER_SRC_LFSR_EN
   logic mode_q, mode_d;

   // An all-zero LFSR state would never leave zero, so seed 0 becomes 1.
   always_comb begin
      seed_eff = seed_i;
      if (mode_i && (seed_i == '0)) begin
         seed_eff = Width'(1);
      end
   end

   always_comb begin
      data_next = data_q + step_q;
      if (mode_q) begin
         data_next = (data_q >> 1) ^ (data_q[0] ? Poly : '0);
      end
   end
`else
   logic unused_poly;
   assign unused_poly = ^Poly;
   assign seed_eff    = seed_i;
   assign data_next   = data_q + step_q;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         num_q     <= '0;
         beats_q   <= '0;
         gap_q     <= '0;
         gap_cnt_q <= '0;
         step_q    <= '0;
         data_q    <= '0;
         done_q    <= 1'b0;
`ifdef ADDER_SRC_LFSR_EN
         mode_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         num_q     <= num_d;
         beats_q   <= beats_d;
         gap_q     <= gap_d;
         gap_cnt_q <= gap_cnt_d;
         step_q    <= step_d;
         data_q    <= data_d;
         done_q    <= done_d;
`ifdef ADDER_SRC_LFSR_EN
         mode_q    <= mode_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      num_d     = num_q;
      beats_d   = beats_q;
      gap_d     = gap_q;
      gap_cnt_d = gap_cnt_q;
      step_d    = step_q;
      data_d    = data_q;
      done_d    = 1'b0;
`ifdef ADDER_SRC_LFSR_EN
      mode_d    = mode_q;
`endif

      unique case (state_q)
         StIdle: begin
            // abort has priority over start, even for an empty burst.
            if (start_i && !abort_i) begin
               beats_d = '0;
               if (num_beats_i == '0) begin
                  done_d = 1'b1;
               end else begin
                  num_d   = num_beats_i;
                  gap_d   = gap_i;
                  step_d  = step_i;
                  data_d  = seed_eff;
`ifdef ADDER_SRC_LFSR_EN
                  mode_d  = mode_i;
`endif
                  state_d = StSend;
               end
            end
         end
         StSend: begin
            // The beat is already on the bus this cycle, so it counts even if aborted.
            beats_d = beats_q + CntW'(1);
            data_d  = data_next;
            if (abort_i) begin
               state_d = StIdle;
            end else if (beats_q == num_q - CntW'(1)) begin
               state_d = StDone;
               done_d  = 1'b1;
            end else if (gap_q != '0) begin
               state_d   = StGap;
               gap_cnt_d = gap_q;
            end
         end
         StGap: begin
            if (abort_i) begin
               state_d = StIdle;
            end else if (gap_cnt_q == GapW'(1)) begin
               state_d   = StSend;
               gap_cnt_d = '0;
            end else begin
               gap_cnt_d = gap_cnt_q - GapW'(1);
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign busy_o       = (state_q != StIdle);
   assign done_o       = done_q;
   assign beats_sent_o = beats_q;
   assign tx.valid     = (state_q == StSend);
   assign tx.data      = (state_q == StSend) ? data_q : '0;

endmodule

// File: tb/tb_adder_stream_src.sv
// Directed bench for adder_stream_src: reset, ramp, gap, edge cases, abort, optional LFSR.
module tb_adder_stream_src;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        abort;
   logic [15:0] num_beats;
   logic [7:0]  gap;
   logic [7:0]  seed;
   logic [7:0]  step;
   logic        mode;
   logic        busy;
   logic        done;
   logic [15:0] beats_sent;

   int checks = 0;
   int errors = 0;

   adder_stream_src_if #(.Width(8)) tx_if ();

   adder_stream_src #(
      .Width(8),
      .CntW (16),
      .GapW (8),
      .Poly (8'hB8)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .start_i     (start),
      .abort_i     (abort),
      .num_beats_i (num_beats),
      .gap_i       (gap),
      .seed_i      (seed),
      .step_i      (step),
`ifdef ADDER_SRC_LFSR_EN
      .mode_i      (mode),
`endif
      .busy_o      (busy),
      .done_o      (done),
      .beats_sent_o(beats_sent),
      .tx          (tx_if)
   );

   always #5 clk = ~clk;

   // Advance one edge; inputs change and outputs are sampled 1 ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [15:0] n, input logic [7:0] g, input logic [7:0] s,
                         input logic [7:0] st, input logic m);
      num_beats = n;
      gap       = g;
      seed      = s;
      step      = st;
      mode      = m;
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      checks++;
      if ({busy, done, tx_if.valid, tx_if.data, beats_sent} !== 27'd0) begin
         errors++;
         $display("FAIL reset_state: got busy=%b done=%b valid=%b data=%h beats=%0d want all 0",
                  busy, done, tx_if.valid, tx_if.data, beats_sent);
      end
      launch(16'd10, 8'd0, 8'h20, 8'd1, 1'b0);
      tick();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({busy, done, tx_if.valid, tx_if.data, beats_sent} !== 27'd0) begin
            errors++;
            $display("FAIL reset_mid_burst[%0d]: got busy=%b done=%b valid=%b data=%h beats=%0d want all 0",
                     i, busy, done, tx_if.valid, tx_if.data, beats_sent);
         end
      end
      rst = 1'b0;
      tick();
      checks++;
      if ({busy, done, tx_if.valid} !== 3'b000) begin
         errors++;
         $display("FAIL reset_release: got busy=%b done=%b valid=%b want 000",
                  busy, done, tx_if.valid);
      end
   endtask

   task automatic test_ramp();
      logic [7:0] exp_d [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
      launch(16'd4, 8'd0, 8'hFE, 8'd1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (tx_if.valid !== 1'b1 || tx_if.data !== exp_d[i] || busy !== 1'b1) begin
            errors++;
            $display("FAIL ramp_beat[%0d]: got valid=%b data=%h busy=%b want 1 %h 1",
                     i, tx_if.valid, tx_if.data, busy, exp_d[i]);
         end
         tick();
      end
      checks++;
      if (done !== 1'b1 || tx_if.valid !== 1'b0) begin
         errors++;
         $display("FAIL ramp_done: got done=%b valid=%b want 1 0", done, tx_if.valid);
      end
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || beats_sent !== 16'd4) begin
         errors++;
         $display("FAIL ramp_end: got done=%b busy=%b beats=%0d want 0 0 4",
                  done, busy, beats_sent);
      end
   endtask

   task automatic test_gap();
      logic       exp_v [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [7:0] exp_d [7] = '{8'd5, 8'd0, 8'd0, 8'd8, 8'd0, 8'd0, 8'd11};
      launch(16'd3, 8'd2, 8'd5, 8'd3, 1'b0);
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (tx_if.valid !== exp_v[i] || tx_if.data !== exp_d[i] || done !== 1'b0) begin
            errors++;
            $display("FAIL gap_cycle[%0d]: got valid=%b data=%0d done=%b want %b %0d 0",
                     i, tx_if.valid, tx_if.data, done, exp_v[i], exp_d[i]);
         end
         tick();
      end
      checks++;
      if (done !== 1'b1 || tx_if.valid !== 1'b0) begin
         errors++;
         $display("FAIL gap_done: got done=%b valid=%b want 1 0", done, tx_if.valid);
      end
      tick();
      checks++;
      if (done !== 1'b0 || beats_sent !== 16'd3) begin
         errors++;
         $display("FAIL gap_end: got done=%b beats=%0d want 0 3", done, beats_sent);
      end
   endtask

   task automatic test_edges();
      int         nvalid = 0;
      bit         seen_done = 1'b0;
      logic [7:0] exp_d [3] = '{8'h10, 8'h11, 8'h12};
      launch(16'd0, 8'd0, 8'h33, 8'd1, 1'b0);
      checks++;
      if (done !== 1'b1 || tx_if.valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL zero_beats: got done=%b valid=%b busy=%b want 1 0 0",
                  done, tx_if.valid, busy);
      end
      tick();
      checks++;
      if (done !== 1'b0 || tx_if.valid !== 1'b0) begin
         errors++;
         $display("FAIL zero_beats_after: got done=%b valid=%b want 0 0", done, tx_if.valid);
      end
      launch(16'd3, 8'd1, 8'h10, 8'd1, 1'b0);
      // A second start mid-burst with different settings must be ignored.
      for (int i = 0; i < 20 && !seen_done; i++) begin
         if (i == 1) begin
            num_beats = 16'd1;
            seed      = 8'h80;
            step      = 8'd7;
            gap       = 8'd0;
            start     = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (tx_if.valid) begin
            checks++;
            if (nvalid > 2 || tx_if.data !== exp_d[nvalid > 2 ? 2 : nvalid]) begin
               errors++;
               $display("FAIL start_busy_beat[%0d]: got data=%h want %h",
                        nvalid, tx_if.data, exp_d[nvalid > 2 ? 2 : nvalid]);
            end
            nvalid++;
         end
         if (done) seen_done = 1'b1;
         else tick();
      end
      start = 1'b0;
      checks++;
      if (!seen_done || nvalid != 3) begin
         errors++;
         $display("FAIL start_busy_count: got done_seen=%b beats=%0d want 1 3", seen_done, nvalid);
      end
      tick();
      checks++;
      if (beats_sent !== 16'd3 || busy !== 1'b0) begin
         errors++;
         $display("FAIL start_busy_end: got beats=%0d busy=%b want 3 0", beats_sent, busy);
      end
   endtask

   task automatic test_abort();
      int nbeats = 0;
      int nbad   = 0;
      launch(16'd10, 8'd1, 8'd0, 8'd1, 1'b0);
      for (int i = 0; i < 10 && nbeats < 3; i++) begin
         if (tx_if.valid) nbeats++;
         if (nbeats < 3) tick();
      end
      checks++;
      if (nbeats != 3 || tx_if.data !== 8'd2) begin
         errors++;
         $display("FAIL abort_third_beat: got beats=%0d data=%0d want 3 2", nbeats, tx_if.data);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || tx_if.valid !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle: got busy=%b valid=%b want 0 0", busy, tx_if.valid);
      end
      for (int i = 0; i < 20; i++) begin
         if (tx_if.valid || done) nbad++;
         tick();
      end
      checks++;
      if (nbad != 0 || beats_sent !== 16'd3) begin
         errors++;
         $display("FAIL abort_quiet: got stray=%0d beats=%0d want 0 3", nbad, beats_sent);
      end
      abort = 1'b1;
      launch(16'd2, 8'd0, 8'd9, 8'd1, 1'b0);
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || tx_if.valid !== 1'b0) begin
         errors++;
         $display("FAIL abort_beats_start: got busy=%b valid=%b want 0 0", busy, tx_if.valid);
      end
      abort = 1'b1;
      launch(16'd0, 8'd0, 8'd9, 8'd1, 1'b0);
      abort = 1'b0;
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL abort_zero_start: got done=%b want 0", done);
      end
   endtask

`ifdef ADDER_SRC_LFSR_EN
   task automatic test_lfsr();
      logic [7:0] exp_d [4] = '{8'h01, 8'hB8, 8'h5C, 8'h2E};
      launch(16'd4, 8'd0, 8'h00, 8'd5, 1'b1);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (tx_if.valid !== 1'b1 || tx_if.data !== exp_d[i]) begin
            errors++;
            $display("FAIL lfsr_beat[%0d]: got valid=%b data=%h want 1 %h",
                     i, tx_if.valid, tx_if.data, exp_d[i]);
         end
         tick();
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL lfsr_done: got done=%b want 1", done);
      end
      tick();
   endtask
`endif

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      abort     = 1'b0;
      num_beats = '0;
      gap       = '0;
      seed      = '0;
      step      = '0;
      mode      = 1'b0;
      #1;
      test_reset();
      test_ramp();
      test_gap();
      test_edges();
      test_abort();
`ifdef ADDER_SRC_LFSR_EN
      test_lfsr();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
